// File: rtl/bcd_score_keeper.sv
// Whack-a-mole score engine: edge-detected hit/miss strobes drive a packed two-digit
// BCD score, a four-state round FSM, and a session high score.
module bcd_score_keeper #(
    parameter logic [3:0] HIT_POINTS   = 4'd1,
    parameter logic [3:0] MISS_PENALTY = 4'd1,
    parameter logic [7:0] WIN_SCORE    = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       time_up,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [1:0] state,
    output logic       new_high
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int NUM_BTN = 2;
    localparam int BTN_HIT  = 0;
    localparam int BTN_MISS = 1;

    state_t      state_reg, state_next;
    logic [7:0]  score_reg, score_next;
    logic [7:0]  high_reg, high_next;
    logic        new_high_reg, new_high_next;
    logic        first_reg, first_next;

    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_q_reg;
    logic [NUM_BTN-1:0] btn_evt;

    logic        hit_evt;
    logic        miss_evt;
    logic [7:0]  add_score;
    logic [7:0]  sub_score;
    logic [7:0]  evt_score;

    assign btn_lvl = {miss, hit};

    // Edge registers preset to 1 on reset so a button held through reset stays silent.
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
            always_ff @(posedge clk) begin
                if (rst) begin
                    btn_q_reg[gi] <= 1'b1;
                end else begin
                    btn_q_reg[gi] <= btn_lvl[gi];
                end
            end
            assign btn_evt[gi] = btn_lvl[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    assign hit_evt  = btn_evt[BTN_HIT];
    assign miss_evt = btn_evt[BTN_MISS];

    // BCD add with single carry into tens; tens overflow saturates at 99.
    function automatic logic [7:0] bcd_add(input logic [7:0] s);
        logic [4:0] ones_sum;
        logic [3:0] ones;
        logic [3:0] tens;
        ones_sum = {1'b0, s[3:0]} + {1'b0, HIT_POINTS};
        tens     = s[7:4];
        if (ones_sum > 5'd9) begin
            ones = 4'(ones_sum - 5'd10);
            if (tens >= 4'd9) begin
                return 8'h99;
            end
            tens = tens + 4'd1;
        end else begin
            ones = ones_sum[3:0];
        end
        return {tens, ones};
    endfunction

    // BCD subtract with borrow; anything below the penalty floors at 00.
    function automatic logic [7:0] bcd_sub(input logic [7:0] s);
        logic [4:0] ones_diff;
        logic [3:0] tens;
        tens = s[7:4];
        if (tens == 4'd0 && s[3:0] < MISS_PENALTY) begin
            return 8'h00;
        end
        if (s[3:0] >= MISS_PENALTY) begin
            ones_diff = {1'b0, s[3:0]} - {1'b0, MISS_PENALTY};
        end else begin
            ones_diff = {1'b0, s[3:0]} + 5'd10 - {1'b0, MISS_PENALTY};
            tens      = tens - 4'd1;
        end
        return {tens, ones_diff[3:0]};
    endfunction

    assign add_score = bcd_add(score_reg);
    assign sub_score = bcd_sub(score_reg);

    // A simultaneous hit and miss counts as the hit alone.
    always_comb begin
        evt_score = score_reg;
        if (hit_evt) begin
            evt_score = add_score;
        end else if (miss_evt) begin
            evt_score = sub_score;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            score_reg    <= 8'h00;
            high_reg     <= 8'h00;
            new_high_reg <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            score_reg    <= score_next;
            high_reg     <= high_next;
            new_high_reg <= new_high_next;
            first_reg    <= first_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        score_next    = score_reg;
        high_next     = high_reg;
        new_high_next = new_high_reg;
        first_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_PLAY;
                    score_next    = 8'h00;
                    new_high_next = 1'b0;
                end
            end

            ST_PLAY: begin
                if (time_up) begin
                    state_next = ST_OVER;
                    first_next = 1'b1;
                end else if (hit_evt || miss_evt) begin
                    score_next = evt_score;
                    // Packed BCD orders the same as decimal, so a plain compare works.
                    if (evt_score >= WIN_SCORE) begin
                        state_next = ST_WIN;
                        first_next = 1'b1;
                    end
                end
            end

            ST_WIN, ST_OVER: begin
                if (first_reg && (score_reg > high_reg)) begin
                    high_next     = score_reg;
                    new_high_next = 1'b1;
                end
                if (start) begin
                    state_next    = ST_PLAY;
                    score_next    = 8'h00;
                    new_high_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign score      = score_reg;
    assign high_score = high_reg;
    assign state      = state_reg;
    assign new_high   = new_high_reg;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Scoreboard bench for bcd_score_keeper: expected scores are queued as stimulus is
// driven and popped after the clock edge that should produce them.
module tb_bcd_score_keeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hit;
    logic       miss;
    logic       time_up;
    logic [7:0] score, high_score;
    logic [1:0] state;
    logic       new_high;
    logic [7:0] score2, high_score2;
    logic [1:0] state2;
    logic       new_high2;

    int         n_cmp = 0;
    int         n_err = 0;
    int         d;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    bcd_score_keeper dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss), .time_up(time_up),
        .score(score), .high_score(high_score), .state(state), .new_high(new_high)
    );

    bcd_score_keeper #(.HIT_POINTS(4'd9), .MISS_PENALTY(4'd1), .WIN_SCORE(8'h99)) dut9 (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss), .time_up(time_up),
        .score(score2), .high_score(high_score2), .state(state2), .new_high(new_high2)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0; time_up = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (score !== 8'h00 || high_score !== 8'h00 || state !== 2'b00 || new_high !== 1'b0) begin
            $display("FAIL reset: got score=%h high=%h state=%b new_high=%b, want 00 00 00 0",
                     score, high_score, state, new_high);
            n_err++;
        end else $display("reset: score=%h high=%h state=%b", score, high_score, state);
        hit = 1'b1; exp_q.push_back(8'h00); tick(); hit = 1'b0; tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v) begin
            $display("FAIL idle_hit: score got %h want %h", score, exp_v); n_err++;
        end else $display("idle_hit: score=%h", score);
    endtask

    task automatic test_hits();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (score !== 8'h00 || state !== 2'b01) begin
            $display("FAIL start: got score=%h state=%b want 00 01", score, state); n_err++;
        end else $display("start: score=%h state=%b", score, state);
        d = 0;
        for (int i = 0; i < 12; i++) begin
            d++;
            exp_q.push_back(to_bcd(d));
            hit = 1'b1; tick();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (score !== exp_v || state !== 2'b01 || score[3:0] > 4'd9 || score[7:4] > 4'd9) begin
                $display("FAIL hit%0d: got score=%h state=%b want %h 01", i, score, state, exp_v);
                n_err++;
            end else $display("hit%0d: score=%h", i, score);
            hit = 1'b0; tick();
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 14; i++) begin
            d = (d > 0) ? d - 1 : 0;
            exp_q.push_back(to_bcd(d));
            miss = 1'b1; tick();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (score !== exp_v) begin
                $display("FAIL miss%0d: score got %h want %h", i, score, exp_v); n_err++;
            end else $display("miss%0d: score=%h", i, score);
            miss = 1'b0; tick();
        end
    endtask

    task automatic test_hold_and_both();
        hit = 1'b1;
        d++;
        exp_q.push_back(to_bcd(d));
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v) begin
            $display("FAIL hold_first: score got %h want %h", score, exp_v); n_err++;
        end else $display("hold_first: score=%h", score);
        exp_q.push_back(to_bcd(d));
        for (int i = 0; i < 19; i++) tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v) begin
            $display("FAIL hold_end: score got %h want %h", score, exp_v); n_err++;
        end else $display("hold_end: score=%h", score);
        hit = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            hit = 1'b1; tick(); hit = 1'b0; tick(); d++;
        end
        d++;
        exp_q.push_back(to_bcd(d));
        hit = 1'b1; miss = 1'b1; tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v) begin
            $display("FAIL hit_and_miss: score got %h want %h", score, exp_v); n_err++;
        end else $display("hit_and_miss: score=%h", score);
        hit = 1'b0; miss = 1'b0; tick();
    endtask

    task automatic test_win();
        while (d < 29) begin
            hit = 1'b1; tick(); hit = 1'b0; tick(); d++;
        end
        d++;
        exp_q.push_back(to_bcd(d));
        hit = 1'b1; tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v || state !== 2'b10) begin
            $display("FAIL win_edge: got score=%h state=%b want %h 10", score, state, exp_v);
            n_err++;
        end else $display("win_edge: score=%h state=%b", score, state);
        hit = 1'b0; tick();
        n_cmp++;
        if (high_score !== 8'h30 || new_high !== 1'b1) begin
            $display("FAIL win_high: got high=%h new_high=%b want 30 1", high_score, new_high);
            n_err++;
        end else $display("win_high: high=%h new_high=%b", high_score, new_high);
        exp_q.push_back(8'h30);
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1; tick(); hit = 1'b0; tick();
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v || state !== 2'b10) begin
            $display("FAIL win_hold: got score=%h state=%b want %h 10", score, state, exp_v);
            n_err++;
        end else $display("win_hold: score=%h", score);
    endtask

    task automatic test_time_up();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (score !== 8'h00 || state !== 2'b01 || new_high !== 1'b0) begin
            $display("FAIL restart: got score=%h state=%b new_high=%b want 00 01 0",
                     score, state, new_high);
            n_err++;
        end else $display("restart: score=%h state=%b", score, state);
        tick();
        for (int i = 0; i < 12; i++) begin
            hit = 1'b1; tick(); hit = 1'b0; tick();
        end
        exp_q.push_back(8'h12);
        hit = 1'b1; time_up = 1'b1; tick();
        hit = 1'b0; time_up = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score !== exp_v || state !== 2'b11) begin
            $display("FAIL time_up: got score=%h state=%b want %h 11", score, state, exp_v);
            n_err++;
        end else $display("time_up: score=%h state=%b", score, state);
        tick();
        n_cmp++;
        if (high_score !== 8'h30 || new_high !== 1'b0) begin
            $display("FAIL over_high: got high=%h new_high=%b want 30 0", high_score, new_high);
            n_err++;
        end else $display("over_high: high=%h new_high=%b", high_score, new_high);
    endtask

    task automatic test_saturate_and_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        d = 0;
        for (int i = 0; i < 12; i++) begin
            d = (d + 9 > 99) ? 99 : d + 9;
            exp_q.push_back(to_bcd(d));
            hit = 1'b1; tick();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (score2 !== exp_v) begin
                $display("FAIL sat_hit%0d: score got %h want %h", i, score2, exp_v); n_err++;
            end else $display("sat_hit%0d: score=%h", i, score2);
            hit = 1'b0; tick();
        end
        n_cmp++;
        if (state2 !== 2'b10) begin
            $display("FAIL sat_win: state got %b want 10", state2); n_err++;
        end else $display("sat_win: state=%b high=%h", state2, high_score2);
        start = 1'b1; tick(); start = 1'b0;
        hit = 1'b1; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if (score2 !== 8'h00 || high_score2 !== 8'h00 || state2 !== 2'b00 || new_high2 !== 1'b0) begin
            $display("FAIL mid_reset: got score=%h high=%h state=%b new_high=%b want 00 00 00 0",
                     score2, high_score2, state2, new_high2);
            n_err++;
        end else $display("mid_reset: score=%h high=%h state=%b", score2, high_score2, state2);
        start = 1'b1; tick(); start = 1'b0;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score2 !== exp_v || state2 !== 2'b01) begin
            $display("FAIL held_after_reset: got score=%h state=%b want %h 01", score2, state2, exp_v);
            n_err++;
        end else $display("held_after_reset: score=%h", score2);
        hit = 1'b0; tick();
        exp_q.push_back(8'h09);
        hit = 1'b1; tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (score2 !== exp_v) begin
            $display("FAIL rearm_hit: score got %h want %h", score2, exp_v); n_err++;
        end else $display("rearm_hit: score=%h", score2);
        hit = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_hits();
        test_miss();
        test_hold_and_both();
        test_win();
        test_time_up();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_score_keeper.md
Name: bcd_score_keeper

Overview:
Game-side score engine for whack-a-mole. Turns hit/miss strobes into a packed two-digit BCD score, {tens[7:4], ones[3:0]}, and runs the round state machine (idle, play, win, time-over). It also tracks the session high score. The score output feeds the two-digit multiplexed 7-segment display stage directly, so both nibbles are always legal BCD (0-9).

Parameters:
HIT_POINTS, 1, BCD points added per hit; legal range 1-9.
MISS_PENALTY, 1, BCD points subtracted per miss; legal range 0-9; 0 disables the penalty.
WIN_SCORE, 8'h30, packed-BCD score that ends the round as a win; legal range 8'h01-8'h99.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; starts or restarts a round
hit  in  1  synchronised level; each rising edge is one hit
miss  in  1  synchronised level; each rising edge is one miss
time_up  in  1  single-cycle pulse from the round timer
score  out  8  packed BCD current score {tens,ones}
high_score  out  8  packed BCD best score this session
state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 OVER
new_high  out  1  high when the last round set a new high score

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - score=8'h00, high_score=8'h00, state=IDLE, new_high=0.
  - Edge-detect registers hit_q and miss_q are set to 1, so a button held through reset produces no event.
- Edge detect:
  - hit_evt = hit & ~hit_q; miss_evt = miss & ~miss_q.
  - hit_q and miss_q register every cycle in every state.
  - A level held high is counted once.
- Latency: an event sampled at edge N updates score at edge N; the new value is visible in the cycle after N.
- BCD add of HIT_POINTS:
  - ones_sum = ones + HIT_POINTS.
  - If ones_sum > 9: ones = ones_sum - 10 and tens increments.
  - If tens would exceed 9, score saturates at 8'h99.
- BCD subtract of MISS_PENALTY:
  - If score (decimal) < MISS_PENALTY, score = 8'h00.
  - Otherwise subtract with borrow from tens. No underflow wrap.
- Simultaneous hit_evt and miss_evt in one cycle: the hit is applied and the miss is dropped.
- FSM:
  - IDLE: score holds; events are ignored. start -> PLAY, with score cleared to 00 on the same edge.
  - PLAY:
    - time_up -> OVER; any event in that same cycle is ignored.
    - Otherwise apply the event. If the updated score >= WIN_SCORE (BCD compare), go to WIN on the same edge the score is written.
    - start in PLAY is ignored.
  - WIN / OVER:
    - score holds; events and time_up are ignored.
    - On the first cycle in WIN/OVER: if score > high_score, then high_score <= score and new_high <= 1.
    - start -> PLAY: score cleared to 00, new_high cleared to 0.
    - If start arrives on that first cycle, the high-score check still executes before the score is cleared.
- Reset mid-round: all state returns to reset values; high_score is lost.
- Precedence: rst > start > time_up > hit > miss.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, start, then 12 hit rising edges 2 cycles apart (defaults) -> score steps 01..09, 10, 11, 12; state=01; nibbles never exceed 9.
2. Score 8'h10, one miss edge -> score 8'h09. Then with score 00, one miss edge -> score stays 00.
3. Hit held high 20 cycles -> exactly one increment. Hit and miss rising edges in the same cycle at score 05 -> score 06.
4. Drive score to 8'h29, one hit -> score 8'h30, state=10 on the same edge. Next cycle high_score=8'h30, new_high=1. Further hits leave score at 30.
5. New round (start) -> score 00, new_high 0. Reach 8'h12, pulse time_up together with a hit -> score 12, state=11, high_score stays 8'h30, new_high=0.
6. Override HIT_POINTS=9, WIN_SCORE=8'h99: 12 hits -> 09, 18, ..., 99, saturating at 8'h99 with WIN. Assert rst mid-play with hit held high -> all outputs reset, and no increment after rst deasserts until hit falls and rises again.
